// File: rtl/tone_seq_beeper.sv
// tone_seq_beeper: note-sequenced square-wave buzzer driver.
// Accepts {note_code, note_dur} over valid/ready and plays each note for
// note_dur duration ticks. After each note it inserts GAP_TICKS silent ticks.
// Half-period counts are derived from CLK_HZ at elaboration.
// Optional feature: define BEEPER_VOLUME_EN to add the 2-bit 'volume' input.
// That input shortens the high phase of the wave to set the loudness.
module tone_seq_beeper #(
   parameter int CLK_HZ    = 12000000,
   parameter int TICK_HZ   = 1000,
   parameter int DUR_W     = 8,
   parameter int GAP_TICKS = 0,
   parameter int CNT_W     = 18
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [4:0]       note_code,
   input  logic [DUR_W-1:0] note_dur,
`ifdef BEEPER_VOLUME_EN
   input  logic [1:0]       volume,
`endif
   input  logic             stop,
   output logic             busy,
   output logic             piano_out
);

   localparam int TICK_CYC = CLK_HZ / TICK_HZ;
   localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   typedef logic [31:0][CNT_W-1:0] half_tab_t;
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   // Half-period table indexed by note code; rest codes hold 0.
   function automatic half_tab_t build_half_tab();
      half_tab_t tab;
      longint    base;
      longint    freq;
      tab = '0;
      for (int c = 1; c <= 21; c++) begin
         case ((c - 1) % 7)
            0:       base = 26163;
            1:       base = 29366;
            2:       base = 32963;
            3:       base = 34923;
            4:       base = 39200;
            5:       base = 44000;
            default: base = 49388;
         endcase
         freq = base * (longint'(1) << ((c - 1) / 7));
         tab[c[4:0]] = CNT_W'((longint'(CLK_HZ) * 50) / freq - 1);
      end
      return tab;
   endfunction

   localparam half_tab_t HALF_TAB = build_half_tab();

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   tone_cnt_q;
   logic [CNT_W-1:0]   half_q;
   logic               rest_q;
   logic               phase_q;
   logic [PRE_W-1:0]   pre_q;
   logic [DUR_W-1:0]   rem_q;
   logic [GAP_W-1:0]   gap_q;
   logic               tick;
   logic               accept;
   logic               code_is_rest;

   assign tick         = (pre_q == PRE_W'(TICK_CYC - 1));
   assign accept       = note_valid && note_ready;
   assign code_is_rest = (note_code == 5'd0) || (note_code > 5'd21);
   assign busy         = (state_q != IDLE);

   // State register.
   // NOTE: asynchronous active-low reset lists negedge rst_n_in in the
   // sensitivity so outputs clear immediately, without waiting for a clock.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state and handshake decode; stop overrides everything.
   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      note_ready = 1'b0;
      case (state_q)
         IDLE: begin
            note_ready = !stop;
            if (note_valid && !stop && (note_dur != '0)) state_d = PLAY;
         end
         PLAY: begin
            if (tick && (rem_q == DUR_W'(1))) state_d = (GAP_TICKS > 0) ? GAP : IDLE;
         end
         GAP: begin
            if (tick && (gap_q == GAP_W'(1))) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (stop) state_d = IDLE;
   end

   // Tone, prescaler, remaining-duration and gap counters.
   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tone_cnt_q <= '0;
         half_q     <= '0;
         rest_q     <= 1'b0;
         phase_q    <= 1'b0;
         pre_q      <= '0;
         rem_q      <= '0;
         gap_q      <= '0;
      end else begin
         case (state_d)
            PLAY: begin
               if (state_q == IDLE) begin
                  // Fresh note: latch it and start counting from zero.
                  half_q     <= HALF_TAB[note_code];
                  rest_q     <= code_is_rest;
                  rem_q      <= note_dur;
                  tone_cnt_q <= '0;
                  pre_q      <= '0;
                  phase_q    <= 1'b0;
               end else begin
                  pre_q <= tick ? '0 : pre_q + PRE_W'(1);
                  if (tick) rem_q <= rem_q - DUR_W'(1);
                  if (tone_cnt_q == half_q) begin
                     tone_cnt_q <= '0;
                     if (!rest_q) phase_q <= ~phase_q;
                  end else begin
                     tone_cnt_q <= tone_cnt_q + CNT_W'(1);
                  end
               end
            end
            GAP: begin
               phase_q    <= 1'b0;
               tone_cnt_q <= '0;
               if (state_q != GAP) begin
                  gap_q <= GAP_W'(GAP_TICKS);
                  pre_q <= '0;
               end else begin
                  pre_q <= tick ? '0 : pre_q + PRE_W'(1);
                  if (tick) gap_q <= gap_q - GAP_W'(1);
               end
            end
            default: begin
               tone_cnt_q <= '0;
               phase_q    <= 1'b0;
               pre_q      <= '0;
               rem_q      <= '0;
               gap_q      <= '0;
            end
         endcase
      end
   end

`ifdef BEEPER_VOLUME_EN
   logic [CNT_W+1:0] thr_calc;
   logic [CNT_W+1:0] thr_q;

   // High-phase on-time for the requested volume: ((HALF+1)*(vol+1))/4.
   always_comb begin
      thr_calc = (((CNT_W+2)'(HALF_TAB[note_code]) + (CNT_W+2)'(1))
                  * (CNT_W+2)'({1'b0, volume} + 3'd1)) >> 2;
   end

   // Volume threshold is captured with the note.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   thr_q <= '0;
      else if (accept) thr_q <= thr_calc;
   end

   assign piano_out = phase_q && ({2'b00, tone_cnt_q} < thr_q);
`else
   assign piano_out = phase_q;
`endif

endmodule

// File: tb/tb_tone_seq_beeper.sv
// tb_tone_seq_beeper: randomized self-checking bench for tone_seq_beeper.
// The reference model tracks elapsed time within the current note. It
// derives busy/ready/piano_out from that time with plain arithmetic.
// The bench runs a scaled clock (1.2 MHz) so each note stays short.
module tb_tone_seq_beeper;

   localparam int CLK_HZ    = 1200000;
   localparam int TICK_HZ   = 1000;
   localparam int DUR_W     = 8;
   localparam int GAP_TICKS = 2;
   localparam int CNT_W     = 18;
   localparam int TICK_CYC  = CLK_HZ / TICK_HZ;

   logic             clk_in     = 1'b0;
   logic             rst_n_in   = 1'b0;
   logic             note_valid = 1'b0;
   logic             stop       = 1'b0;
   logic [4:0]       note_code  = '0;
   logic [DUR_W-1:0] note_dur   = '0;
   logic             note_ready;
   logic             busy;
   logic             piano_out;
`ifdef BEEPER_VOLUME_EN
   logic [1:0]       volume = 2'd3;
`endif

   tone_seq_beeper #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DUR_W(DUR_W),
      .GAP_TICKS(GAP_TICKS), .CNT_W(CNT_W)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .note_valid(note_valid),
      .note_ready(note_ready),
      .note_code(note_code),
      .note_dur(note_dur),
`ifdef BEEPER_VOLUME_EN
      .volume(volume),
`endif
      .stop(stop),
      .busy(busy),
      .piano_out(piano_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int code;
      int dur;
      int vol;
   } note_t;

   note_t pend[$];
   int    n_checks  = 0;
   int    n_fail    = 0;
   int    stop_after = -1;
   int    stop_cnt  = 0;

   // Model of the note being played.
   bit    m_active  = 1'b0;
   bit    m_rest    = 1'b0;
   int    m_elapsed = 0;
   int    m_play    = 0;
   int    m_total   = 0;
   int    m_half    = 0;
   int    m_thr     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int half_of(input int code);
      int     base[7];
      longint f;
      base = '{26163, 29366, 32963, 34923, 39200, 44000, 49388};
      f = longint'(base[(code - 1) % 7]) * (longint'(1) << ((code - 1) / 7));
      return int'((longint'(CLK_HZ) * 50) / f - 1);
   endfunction

   function automatic bit exp_piano();
      if (!m_active || m_rest || (m_elapsed >= m_play)) return 1'b0;
      if (((m_elapsed / (m_half + 1)) % 2) == 0) return 1'b0;
      return (m_elapsed % (m_half + 1)) < m_thr;
   endfunction

   // One clock: compare outputs, drive inputs, advance the model.
   task automatic step();
      note_t n;
      @(negedge clk_in);
      check("busy", busy, m_active);
      check("note_ready", note_ready, !m_active && !stop);
      check("piano_out", piano_out, exp_piano());
      if ((stop_cnt == 0) && (stop_after >= 0) && m_active && (m_elapsed == stop_after)) begin
         stop_cnt   = 3;
         stop_after = -1;
      end
      stop = (stop_cnt > 0);
      if (stop_cnt > 0) stop_cnt--;
      note_valid = (pend.size() > 0);
      if (note_valid) begin
         note_code = 5'(pend[0].code);
         note_dur  = DUR_W'(pend[0].dur);
`ifdef BEEPER_VOLUME_EN
         volume    = 2'(pend[0].vol);
`endif
      end
      if (stop) begin
         m_active = 1'b0;
      end else if (m_active) begin
         m_elapsed++;
         if (m_elapsed == m_total) m_active = 1'b0;
      end else if (note_valid) begin
         n = pend.pop_front();
         if (n.dur != 0) begin
            m_active  = 1'b1;
            m_elapsed = 0;
            m_play    = n.dur * TICK_CYC;
            m_total   = (n.dur + GAP_TICKS) * TICK_CYC;
            m_rest    = (n.code == 0) || (n.code > 21);
            m_half    = m_rest ? 0 : half_of(n.code);
`ifdef BEEPER_VOLUME_EN
            m_thr     = ((m_half + 1) * (n.vol + 1)) >> 2;
`else
            m_thr     = m_half + 1;
`endif
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while ((pend.size() > 0 || m_active || stop_cnt > 0 || stop) && (i < budget)) begin
         step();
         i++;
      end
      step();
      if (i >= budget) check("idle_timeout", 32'(i), 32'(budget - 1));
      stop_after = -1;
   endtask

   initial begin
      // Reset state, observed while reset is held.
      #1;
      check("rst_piano", piano_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", note_ready, 1'b1);
      #11 rst_n_in = 1'b1;

      // L1 for two ticks, then the gap.
      pend.push_back('{1, 2, 3});
      wait_idle(20000);

      // H5 then M1 with note_valid held between them.
      pend.push_back('{19, 1, 0});
      pend.push_back('{8, 1, 3});
      wait_idle(20000);

      // Rest codes and zero-duration notes.
      pend.push_back('{0, 3, 3});
      pend.push_back('{25, 1, 3});
      pend.push_back('{5, 0, 3});
      pend.push_back('{31, 0, 1});
      wait_idle(20000);

      // Stop mid-PLAY while the next note is already pending.
      pend.push_back('{19, 2, 1});
      pend.push_back('{8, 1, 2});
      stop_after = 500;
      wait_idle(20000);

      // Asynchronous reset during the high half of an L1 note.
      pend.push_back('{1, 3, 3});
      for (int i = 0; (i < 5000) && !(m_active && (m_elapsed == 3000)); i++) step();
      #2;
      check("pre_rst_piano", piano_out, 1'b1);
      rst_n_in   = 1'b0;
      note_valid = 1'b0;
      stop       = 1'b0;
      stop_cnt   = 0;
      pend.delete();
      #1;
      check("async_rst_piano", piano_out, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_ready", note_ready, 1'b1);
      m_active = 1'b0;
      #1 rst_n_in = 1'b1;

      // Randomized notes with occasional stops.
      for (int k = 0; k < 8; k++) begin
         pend.push_back('{int'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3))});
         if ($urandom_range(0, 2) == 0) stop_after = int'($urandom_range(0, 2000));
         wait_idle(20000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
